// File: rtl/crc8_frame_tx.sv
// Transmit framer: buffers one payload packet, then sends it as
// [LEN][payload...][CRC8]. The CRC (MSB-first, no reflection, no final XOR)
// covers LEN and the payload, so a receiver running the same CRC over the
// whole frame, CRC byte included, ends with a zero residue.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | accepting payload bytes into the buffer (s_ready high)
// ST_HDR  | presenting the LEN byte
// ST_DATA | presenting buffered payload byte pay_buf[idx]
// ST_CRC  | presenting the CRC byte with m_last
module crc8_frame_tx #(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] POLY    = 8'h07,
   parameter logic [7:0] INIT    = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic       busy,
   output logic       err_trunc
);

   localparam int         IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

   typedef enum logic [1:0] {ST_FILL, ST_HDR, ST_DATA, ST_CRC} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] pay_buf [MAX_LEN];
   logic [7:0] cnt;
   logic [7:0] idx;
   logic [7:0] crc;
   logic       live;
   logic       err_q;
   logic       s_beat;
   logic       m_beat;
   logic       fill_done;

   function automatic logic [7:0] crc_step(input logic [7:0] c_in, input logic [7:0] b);
      logic [7:0] c;
      c = c_in ^ b;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
      end
      return c;
   endfunction

   // live holds s_ready low while reset is asserted and for the release cycle
   assign s_ready   = live & (state == ST_FILL);
   assign m_valid   = (state != ST_FILL);
   assign s_beat    = s_valid & s_ready;
   assign m_beat    = m_valid & m_ready;
   assign fill_done = s_beat & (s_last | (cnt == LAST_IDX));
   assign busy      = (state != ST_FILL) | (cnt != 8'd0);
   assign err_trunc = err_q;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_FILL;
      else      state <= state_nxt;
   end

   // next-state and frame byte selection
   always_comb begin
      state_nxt = state;
      m_data    = 8'h00;
      m_last    = 1'b0;
      case (state)
         ST_FILL: begin
            if (fill_done) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            m_data = cnt;
            if (m_beat) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            m_data = pay_buf[idx[IW-1:0]];
            if (m_beat && (idx == cnt - 8'd1)) state_nxt = ST_CRC;
         end
         ST_CRC: begin
            m_data = crc;
            m_last = 1'b1;
            if (m_beat) state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   // counters, running CRC and truncation pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= 8'd0;
         idx   <= 8'd0;
         crc   <= INIT;
         live  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         live  <= 1'b1;
         err_q <= s_beat & ~s_last & (cnt == LAST_IDX);
         if (s_beat) cnt <= cnt + 8'd1;
         case (state)
            ST_HDR: if (m_beat) begin
               crc <= crc_step(INIT, cnt);
               idx <= 8'd0;
            end
            ST_DATA: if (m_beat) begin
               crc <= crc_step(crc, pay_buf[idx[IW-1:0]]);
               idx <= idx + 8'd1;
            end
            ST_CRC: if (m_beat) begin
               cnt <= 8'd0;
               idx <= 8'd0;
               crc <= INIT;
            end
            default: ;
         endcase
      end
   end

   // payload buffer; contents need no reset
   always_ff @(posedge clk) begin
      if (s_beat) pay_buf[cnt[IW-1:0]] <= s_data;
   end

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Bench for crc8_frame_tx: expected frames are queued as stimulus is driven,
// a monitor pops and compares every output beat, checks hold-under-stall and
// the receiver residue at each frame end.
module tb_crc8_frame_tx;

   localparam int MAX_LEN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_ready = 1'b1;
   logic       busy;
   logic       err_trunc;

   int n_checks = 0;
   int n_errs   = 0;
   int rdy_mode = 0;
   int rdy_ph   = 0;
   int trunc_cnt = 0;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] pl[$];

   crc8_frame_tx #(.MAX_LEN(MAX_LEN), .POLY(8'h07), .INIT(8'h00)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .err_trunc(err_trunc)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // bit-serial reference: feedback of msb xor incoming bit
   function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] b);
      logic [7:0] c;
      logic       fb;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ b[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   task automatic push_exp(input logic [7:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [7:0] bytes[$]);
      logic [7:0] c;
      c = ref_crc(8'h00, 8'(bytes.size()));
      push_exp(8'(bytes.size()), 1'b0);
      foreach (bytes[i]) begin
         push_exp(bytes[i], 1'b0);
         c = ref_crc(c, bytes[i]);
      end
      push_exp(c, 1'b1);
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l);
      logic acc;
      int   t;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) check_eq("s_accept_timeout", 32'(acc), 1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // splits a byte stream into frames the way the framer should, queues them, then drives it
   task automatic send_stream(input logic [7:0] bytes[$]);
      logic [7:0] cur[$];
      cur = {};
      foreach (bytes[i]) begin
         cur.push_back(bytes[i]);
         if ((i == bytes.size() - 1) || (cur.size() == MAX_LEN)) begin
            push_frame(cur);
            cur = {};
         end
      end
      foreach (bytes[i]) push_byte(bytes[i], i == bytes.size() - 1);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq("drain", 32'(exp_q.size()), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // downstream ready pattern: 0 = always ready, 1 = 1,0,0 repeating
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 1) m_ready = (rdy_ph % 3 == 0);
      else               m_ready = 1'b1;
      rdy_ph++;
   end

   logic [7:0] mon_crc = 8'h00;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;

   // output monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         mon_crc    = 8'h00;
         prev_stall = 1'b0;
      end else begin
         check_eq("s_ready_excl", 32'(s_ready & m_valid), 0);
         if (prev_stall) begin
            check_eq("hold_valid", 32'(m_valid), 1);
            check_eq("hold_data", 32'(m_data), 32'(prev_data));
            check_eq("hold_last", 32'(m_last), 32'(prev_last));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_byte", 32'(exp_q.size()), 1);
            end else begin
               e = exp_q.pop_front();
               check_eq("m_data", 32'(m_data), 32'(e.d));
               check_eq("m_last", 32'(m_last), 32'(e.l));
            end
            mon_crc = ref_crc(mon_crc, m_data);
            if (m_last) begin
               check_eq("residue", 32'(mon_crc), 0);
               mon_crc = 8'h00;
            end
         end
         prev_stall = m_valid & ~m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (err_trunc) trunc_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int low;
      int t;
      int tbase;

      // reset values
      #12;
      check_eq("rst_s_ready", 32'(s_ready), 0);
      check_eq("rst_m_valid", 32'(m_valid), 0);
      check_eq("rst_m_data", 32'(m_data), 0);
      check_eq("rst_m_last", 32'(m_last), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_err_trunc", 32'(err_trunc), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      check_eq("release_s_ready", 32'(s_ready), 0);
      @(posedge clk);
      #1;
      check_eq("first_s_ready", 32'(s_ready), 1);

      // {00} -> 01 00 15, s_ready gap of 3
      push_exp(8'h01, 1'b0);
      push_exp(8'h00, 1'b0);
      push_exp(8'h15, 1'b1);
      push_byte(8'h00, 1'b1);
      check_eq("busy_after_accept", 32'(busy), 1);
      low = 0;
      while (!s_ready && low < 20) begin
         low++;
         @(posedge clk);
         #1;
      end
      check_eq("s_ready_gap", 32'(low), 3);
      wait_drain();

      // {A5} -> 01 A5 67
      push_exp(8'h01, 1'b0);
      push_exp(8'hA5, 1'b0);
      push_exp(8'h67, 1'b1);
      push_byte(8'hA5, 1'b1);
      wait_drain();

      // {A5,5A} with toggling m_ready
      rdy_mode = 1;
      pl = {8'hA5, 8'h5A};
      send_stream(pl);
      wait_drain();
      rdy_mode = 0;

      // truncation: 6 bytes into MAX_LEN=4
      tbase = trunc_cnt;
      pl = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
      send_stream(pl);
      wait_drain();
      check_eq("trunc_pulses", 32'(trunc_cnt - tbase), 1);

      // reset during DATA at idx=1
      push_exp(8'h03, 1'b0);
      push_exp(8'hA1, 1'b0);
      push_byte(8'hA1, 1'b0);
      push_byte(8'hA2, 1'b0);
      push_byte(8'hA3, 1'b1);
      t = 0;
      while (!(m_valid && m_data == 8'hA2) && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq("rst_wait_idx1", 32'(m_data), 32'h0A2);
      #1 rst = 1'b0;
      #1;
      check_eq("midrst_m_valid", 32'(m_valid), 0);
      check_eq("midrst_busy", 32'(busy), 0);
      check_eq("midrst_s_ready", 32'(s_ready), 0);
      check_eq("midrst_sb_empty", 32'(exp_q.size()), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      push_exp(8'h01, 1'b0);
      push_exp(8'h00, 1'b0);
      push_exp(8'h15, 1'b1);
      push_byte(8'h00, 1'b1);
      wait_drain();

      // back-to-back single-byte packets
      pl = {8'h01};
      send_stream(pl);
      pl = {8'h02};
      send_stream(pl);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
